xoodyak_cmd_sequencer: RTL and testbench
========================================

XOODYAK_CMD_SEQUENCER -- requirements
Module: xoodyak_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 48, number of command slots.
REQ-002 Parameter OP_W, default 4, opmode width (0 idle, 1 init, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet).
REQ-003 Parameter TEXT_W, default 192, text-block width.
REQ-004 Parameter TIMEOUT, default 64, maximum cycles to wait for core_finished.
REQ-005 Derived constant AW = clog2(DEPTH).
REQ-006 eph1  in  1  sole clock; all state changes on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 load_en  in  1  write one command slot this cycle.
REQ-009 load_addr  in  AW  slot index for load.
REQ-010 load_op  in  OP_W  opmode to store.
REQ-011 load_text  in  TEXT_W  text block to store.
REQ-012 seq_len  in  AW+1  number of slots to play, sampled on accepted start.
REQ-013 loop_en  in  1  replay from slot 0 after last slot, sampled on accepted start.
REQ-014 start  in  1  begin playback.
REQ-015 abort  in  1  stop playback.
REQ-016 core_finished  in  1  core completion strobe.
REQ-017 opmode  out  OP_W  command to core.
REQ-018 textin  out  TEXT_W  text block to core.
REQ-019 cmd_valid  out  1  one-cycle issue strobe.
REQ-020 cmd_idx  out  AW  slot currently issued/awaited.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 seq_done  out  1  one-cycle completion pulse.
REQ-023 timeout_err  out  1  sticky watchdog flag.

Function
REQ-024 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-025 load_en SHALL write slot load_addr only in IDLE; ignored otherwise; load_addr >= DEPTH ignored.
REQ-026 IDLE: start with 1 <= seq_len <= DEPTH SHALL latch seq_len/loop_en, clear timeout_err, set cmd_idx=0, go ISSUE; other seq_len values ignore start.
REQ-027 ISSUE, slot opmode nonzero: cmd_valid=1 for exactly that cycle, opmode/textin = slot contents, go WAIT, watchdog cleared.
REQ-028 ISSUE, slot opmode zero: no cmd_valid, advance as if finished (REQ-030) without entering WAIT.
REQ-029 WAIT: opmode/textin SHALL hold slot contents stable; watchdog increments each cycle.
REQ-030 WAIT with core_finished: if cmd_idx < len-1 -> cmd_idx+1, ISSUE; else if loop_en -> cmd_idx=0, ISSUE; else DONE.
REQ-031 WAIT: watchdog reaching TIMEOUT-1 without core_finished SHALL set timeout_err, go IDLE, no seq_done.
REQ-032 core_finished in IDLE, ISSUE or DONE SHALL be ignored.
REQ-033 DONE: seq_done=1 for one cycle, then IDLE.
REQ-034 abort in any non-IDLE state SHALL force IDLE next cycle, priority over core_finished and timeout; no seq_done.
REQ-035 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, start ignored.
REQ-036 In IDLE, DONE: opmode=0, textin=0, cmd_valid=0.
REQ-037 Sequence latency: first cmd_valid exactly 1 cycle after accepted start.

Reset
REQ-038 reset_n low SHALL asynchronously force IDLE, cmd_idx=0, watchdog=0, opmode=0, textin=0, cmd_valid=0, busy=0, seq_done=0, timeout_err=0.
REQ-039 Command memory contents SHALL NOT be reset; reset mid-playback abandons the sequence.

Structure
REQ-040 Opmode enum, FSM state typedef and default parameters SHALL live in shared package xoodyak_pkg.
REQ-041 Command storage SHALL be sub-module xoodyak_cmd_mem (DEPTH x (OP_W+TEXT_W), 1 write port, 1 combinational read port).

Verification
REQ-042 Load slots 0..2 = {1,2,3}, seq_len=3, loop_en=0, start, finished 3 cycles after each cmd_valid -> three cmd_valid with opmode 1,2,3, cmd_idx 0,1,2, one seq_done, busy falls.
REQ-043 Slots {1,0,6}, seq_len=3 -> cmd_valid only for opmodes 1 and 6; slot 1 consumes one ISSUE cycle.
REQ-044 seq_len=2, loop_en=1, finished always 2 cycles late -> opmode pattern 1,2,1,2... until abort; abort during WAIT -> IDLE next cycle, no seq_done.
REQ-045 TIMEOUT=64, core_finished never asserted -> timeout_err=1 exactly 64 cycles after cmd_valid, busy=0; next accepted start clears it.
REQ-046 seq_len=0 and seq_len=DEPTH+1 start -> stays IDLE; start and load_en during playback -> no effect on outputs or memory.
REQ-047 reset_n asserted mid-WAIT -> outputs zero immediately (asynchronously); after release, replay same sequence without reload -> identical opmode/textin.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// Shared types and default sizing for the Xoodyak command sequencer.
package xoodyak_pkg;

  localparam int DEF_DEPTH   = 48;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_TEXT_W  = 192;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [3:0] {
    OP_IDLE    = 4'd0,
    OP_INIT    = 4'd1,
    OP_NONCE   = 4'd2,
    OP_ASSOC   = 4'd3,
    OP_CRYPT   = 4'd4,
    OP_DECRYPT = 4'd5,
    OP_SQUEEZE = 4'd6,
    OP_RATCHET = 4'd7
  } opmode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/xoodyak_cmd_mem.sv
// Command slot storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a sequence survives a reset.
module xoodyak_cmd_mem
  import xoodyak_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int OP_W   = DEF_OP_W,
  parameter int TEXT_W = DEF_TEXT_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [OP_W-1:0]   wr_op,
  input  logic [TEXT_W-1:0] wr_text,
  input  logic [AW-1:0]     rd_addr,
  output logic [OP_W-1:0]   rd_op,
  output logic [TEXT_W-1:0] rd_text
);

  logic [OP_W+TEXT_W-1:0] mem [DEPTH];

  // slot write; caller guarantees wr_addr < DEPTH when wr_en is high
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_op, wr_text};
  end

  assign {rd_op, rd_text} = mem[rd_addr];

endmodule

// File: rtl/xoodyak_cmd_sequencer.sv
// Plays a programmed list of Xoodyak opmodes/text blocks into the core,
// waiting for core_finished after each issued command, with watchdog.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | slots writable, waiting for a start with a legal seq_len
//  ISSUE    | one cycle: present slot; strobe cmd_valid if opmode nonzero
//  WAIT     | hold slot on outputs until core_finished, abort or timeout
//  DONE     | one-cycle seq_done pulse, then back to IDLE
module xoodyak_cmd_sequencer
  import xoodyak_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int OP_W    = DEF_OP_W,
  parameter int TEXT_W  = DEF_TEXT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int AW     = $clog2(DEPTH),
  localparam int WD_W   = $clog2(TIMEOUT)
) (
  input  logic              eph1,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [OP_W-1:0]   load_op,
  input  logic [TEXT_W-1:0] load_text,
  input  logic [AW:0]       seq_len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  input  logic              core_finished,
  output logic [OP_W-1:0]   opmode,
  output logic [TEXT_W-1:0] textin,
  output logic              cmd_valid,
  output logic [AW-1:0]     cmd_idx,
  output logic              busy,
  output logic              seq_done,
  output logic              timeout_err
);

  seq_state_e        state;
  logic [AW:0]       len_q;
  logic              loop_q;
  logic [WD_W-1:0]   wd;

  logic              wr_ok;
  logic              len_ok;
  logic              last;
  logic              adv_end;
  logic [AW-1:0]     adv_idx;
  logic [AW-1:0]     rd_addr;
  logic [OP_W-1:0]   rd_op;
  logic [TEXT_W-1:0] rd_text;

  assign wr_ok   = load_en && (state == ST_IDLE) && ({1'b0, load_addr} < (AW+1)'(DEPTH));
  assign len_ok  = (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));
  assign last    = ({1'b0, cmd_idx} == (len_q - (AW+1)'(1)));
  assign adv_idx = last ? '0 : cmd_idx + AW'(1);
  assign adv_end = last && !loop_q;
  // the read port looks ahead at the slot about to be issued so outputs can be registered
  assign rd_addr = (state == ST_IDLE) ? '0 : adv_idx;
  assign busy    = (state != ST_IDLE);

  xoodyak_cmd_mem #(
    .DEPTH  (DEPTH),
    .OP_W   (OP_W),
    .TEXT_W (TEXT_W)
  ) u_mem (
    .clk     (eph1),
    .wr_en   (wr_ok),
    .wr_addr (load_addr),
    .wr_op   (load_op),
    .wr_text (load_text),
    .rd_addr (rd_addr),
    .rd_op   (rd_op),
    .rd_text (rd_text)
  );

  // sequencing FSM with registered core-facing outputs; wd counts cycles since issue
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      loop_q      <= 1'b0;
      wd          <= '0;
      cmd_idx     <= '0;
      opmode      <= '0;
      textin      <= '0;
      cmd_valid   <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      seq_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort && len_ok) begin
            state       <= ST_ISSUE;
            len_q       <= seq_len;
            loop_q      <= loop_en;
            timeout_err <= 1'b0;
            cmd_idx     <= '0;
            opmode      <= rd_op;
            textin      <= rd_text;
            cmd_valid   <= (rd_op != '0);
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (abort) begin
            state  <= ST_IDLE;
            opmode <= '0;
            textin <= '0;
          end else if ((state == ST_ISSUE) && (opmode != '0)) begin
            state <= ST_WAIT;
            wd    <= WD_W'(1);
          end else if ((state == ST_ISSUE) || core_finished) begin
            if (adv_end) begin
              state    <= ST_DONE;
              seq_done <= 1'b1;
              opmode   <= '0;
              textin   <= '0;
            end else begin
              state     <= ST_ISSUE;
              cmd_idx   <= adv_idx;
              opmode    <= rd_op;
              textin    <= rd_text;
              cmd_valid <= (rd_op != '0);
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
            opmode      <= '0;
            textin      <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// Scoreboard bench for xoodyak_cmd_sequencer: directed sequences push expected
// issue/done events; a negedge monitor pops and compares them.
module tb_xoodyak_cmd_sequencer;

  localparam int DEPTH  = 48;
  localparam int OP_W   = 4;
  localparam int TEXT_W = 192;
  localparam int AW     = 6;

  logic              eph1 = 1'b0;
  logic              reset_n = 1'b0;
  logic              load_en = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [OP_W-1:0]   load_op = '0;
  logic [TEXT_W-1:0] load_text = '0;
  logic [AW:0]       seq_len = '0;
  logic              loop_en = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              core_finished = 1'b0;
  logic [OP_W-1:0]   opmode;
  logic [TEXT_W-1:0] textin;
  logic              cmd_valid;
  logic [AW-1:0]     cmd_idx;
  logic              busy;
  logic              seq_done;
  logic              timeout_err;

  xoodyak_cmd_sequencer dut (
    .eph1          (eph1),
    .reset_n       (reset_n),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_op       (load_op),
    .load_text     (load_text),
    .seq_len       (seq_len),
    .loop_en       (loop_en),
    .start         (start),
    .abort         (abort),
    .core_finished (core_finished),
    .opmode        (opmode),
    .textin        (textin),
    .cmd_valid     (cmd_valid),
    .cmd_idx       (cmd_idx),
    .busy          (busy),
    .seq_done      (seq_done),
    .timeout_err   (timeout_err)
  );

  always #5 eph1 = ~eph1;

  typedef struct {
    bit              is_done;
    logic [OP_W-1:0] op;
    logic [AW-1:0]   idx;
    logic [TEXT_W-1:0] text;
  } exp_t;

  exp_t exp_q[$];
  int   cmd_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_cmd = 0;
  int   n_done = 0;
  int   fin_delay = 3;
  int   start_cyc = 0;

  always @(posedge eph1) cyc <= cyc + 1;

  function automatic logic [TEXT_W-1:0] mk_text(input int tag);
    logic [31:0] w;
    w = 32'hA5C3_0000 + 32'(tag * 17);
    return {w, ~w, w ^ 32'h1234_5678, w + 32'd1, ~w ^ 32'h0F0F_0F0F, w};
  endfunction

  // scoreboard monitor: every issue strobe or done pulse must match the queue head
  always @(negedge eph1) begin
    exp_t e;
    if (reset_n && (cmd_valid || seq_done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cmd_valid=%0b seq_done=%0b op=%0d idx=%0d",
                 cmd_valid, seq_done, opmode, cmd_idx);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done != seq_done ||
            (!e.is_done && (!cmd_valid || opmode != e.op || cmd_idx != e.idx || textin != e.text))) begin
          errors++;
          $display("FAIL event actual done=%0b valid=%0b op=%0d idx=%0d text_ok=%0b required done=%0b op=%0d idx=%0d",
                   seq_done, cmd_valid, opmode, cmd_idx, (textin == e.text), e.is_done, e.op, e.idx);
        end
      end
      if (cmd_valid) begin
        cmd_cyc.push_back(cyc);
        n_cmd++;
      end
      if (seq_done) n_done++;
    end
  end

  // core model: pulse core_finished fin_delay cycles after each issue (never if negative)
  initial begin
    forever begin
      @(negedge eph1);
      if (reset_n && cmd_valid && fin_delay >= 0) begin
        repeat (fin_delay) @(posedge eph1);
        #1 core_finished = 1'b1;
        @(posedge eph1);
        #1 core_finished = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [TEXT_W-1:0] act, input logic [TEXT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge eph1);
      #1;
    end
  endtask

  task automatic load_slot(input int a, input int op, input int tag);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_op   = OP_W'(op);
    load_text = mk_text(tag);
    step(1);
    load_en   = 1'b0;
  endtask

  task automatic do_start(input int len, input bit lp);
    seq_len   = (AW+1)'(len);
    loop_en   = lp;
    start     = 1'b1;
    start_cyc = cyc;
    step(1);
    start     = 1'b0;
  endtask

  task automatic push_cmd(input int op, input int idx, input int tag);
    exp_t e;
    e.is_done = 1'b0;
    e.op      = OP_W'(op);
    e.idx     = AW'(idx);
    e.text    = mk_text(tag);
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.op      = '0;
    e.idx     = '0;
    e.text    = '0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = n_done;
    int k  = 0;
    while (n_done == d0 && k < budget) begin
      step(1);
      k++;
    end
    chk(name, TEXT_W'(n_done != d0), TEXT_W'(1));
  endtask

  task automatic wait_cmds(input string name, input int target, input int budget);
    int k = 0;
    while (n_cmd < target && k < budget) begin
      step(1);
      k++;
    end
    chk(name, TEXT_W'(n_cmd >= target), TEXT_W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit cycles=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int c0;
    int k;
    // reset state
    #12;
    chk("reset_outputs", TEXT_W'({opmode, cmd_valid, cmd_idx, busy, seq_done, timeout_err}), '0);
    chk("reset_textin", textin, '0);
    @(posedge eph1);
    #1 reset_n = 1'b1;
    step(1);

    // basic three-command sequence, finished 3 cycles after each issue
    load_slot(0, 1, 10);
    load_slot(1, 2, 11);
    load_slot(2, 3, 12);
    fin_delay = 3;
    push_cmd(1, 0, 10); push_cmd(2, 1, 11); push_cmd(3, 2, 12); push_done();
    c0 = cmd_cyc.size();
    do_start(3, 1'b0);
    wait_done("basic_done", 60);
    chk("basic_busy_low", TEXT_W'(busy), '0);
    chk("first_issue_latency", TEXT_W'(cmd_cyc[c0] - start_cyc), TEXT_W'(1));
    chk("issue_gap_normal", TEXT_W'(cmd_cyc[c0+1] - cmd_cyc[c0]), TEXT_W'(4));

    // zero opmode slot is skipped in a single ISSUE cycle
    load_slot(1, 0, 21);
    load_slot(2, 6, 22);
    push_cmd(1, 0, 10); push_cmd(6, 2, 22); push_done();
    c0 = cmd_cyc.size();
    do_start(3, 1'b0);
    wait_done("skip_done", 60);
    chk("issue_gap_skip", TEXT_W'(cmd_cyc[c0+1] - cmd_cyc[c0]), TEXT_W'(5));

    // looping two-slot sequence, aborted during WAIT
    load_slot(1, 2, 11);
    fin_delay = 2;
    push_cmd(1, 0, 10); push_cmd(2, 1, 11); push_cmd(1, 0, 10); push_cmd(2, 1, 11); push_cmd(1, 0, 10);
    c0 = n_cmd;
    do_start(2, 1'b1);
    wait_cmds("loop_issues", c0 + 5, 60);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_idle", TEXT_W'({busy, cmd_valid, opmode}), '0);
    c0 = n_done;
    step(6);
    chk("abort_no_done", TEXT_W'(n_done - c0), '0);

    // watchdog: core never finishes
    fin_delay = -1;
    load_slot(0, 4, 30);
    push_cmd(4, 0, 30);
    c0 = cmd_cyc.size();
    do_start(1, 1'b0);
    k = 0;
    while (!timeout_err && k < 100) begin
      step(1);
      k++;
    end
    chk("timeout_set", TEXT_W'(timeout_err), TEXT_W'(1));
    chk("timeout_latency", TEXT_W'(cyc - cmd_cyc[c0]), TEXT_W'(64));
    chk("timeout_busy_low", TEXT_W'(busy), '0);

    // illegal lengths and start+abort leave the block idle
    do_start(0, 1'b0);
    chk("len0_idle", TEXT_W'(busy), '0);
    do_start(DEPTH + 1, 1'b0);
    chk("len_over_idle", TEXT_W'(busy), '0);
    abort = 1'b1;
    do_start(1, 1'b0);
    abort = 1'b0;
    chk("start_abort_idle", TEXT_W'(busy), '0);
    chk("timeout_sticky", TEXT_W'(timeout_err), TEXT_W'(1));

    // start and load during playback have no effect
    load_slot(0, 1, 10);
    fin_delay = 3;
    push_cmd(1, 0, 10); push_cmd(2, 1, 11); push_cmd(6, 2, 22); push_done();
    do_start(3, 1'b0);
    chk("start_clears_timeout", TEXT_W'(timeout_err), '0);
    seq_len = 7'd1;
    start = 1'b1;
    load_en = 1'b1; load_addr = 6'd1; load_op = 4'd7; load_text = mk_text(99);
    step(2);
    start = 1'b0;
    load_en = 1'b0;
    wait_done("busy_ignore_done", 60);
    push_cmd(1, 0, 10); push_cmd(2, 1, 11); push_cmd(6, 2, 22); push_done();
    do_start(3, 1'b0);
    wait_done("mem_untouched_done", 60);

    // asynchronous reset mid-WAIT, then replay without reload
    load_slot(0, 3, 40);
    load_slot(1, 5, 41);
    load_slot(2, 7, 42);
    fin_delay = -1;
    push_cmd(3, 0, 40);
    c0 = n_cmd;
    do_start(3, 1'b0);
    wait_cmds("reset_test_issue", c0 + 1, 10);
    step(2);
    chk("wait_hold_op", TEXT_W'({busy, cmd_valid, opmode}), TEXT_W'({1'b1, 1'b0, 4'd3}));
    chk("wait_hold_text", textin, mk_text(40));
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", TEXT_W'({opmode, cmd_valid, cmd_idx, busy, seq_done, timeout_err}), '0);
    chk("async_reset_textin", textin, '0);
    @(posedge eph1);
    #1 reset_n = 1'b1;
    step(1);
    fin_delay = 3;
    push_cmd(3, 0, 40); push_cmd(5, 1, 41); push_cmd(7, 2, 42); push_done();
    do_start(3, 1'b0);
    wait_done("replay_done", 60);

    step(8);
    chk("scoreboard_drained", TEXT_W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
